// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
package fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
    } if_id_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer parking a fetched word while decode is stalled.
// Clear has priority over load, load over unload.
module fetch_hold_buf
    import fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   unload,
    input  logic   clear,
    input  if_id_t word,
    output if_id_t held,
    output logic   full
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held <= '0;
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            held <= word;
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, imem handshake, IF/ID register.
// Define FETCH_PERF_CNT_EN to add stall_cycles and squash_count outputs.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            PCSrcD,
    input  logic [XLEN-1:0] PCBranchD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic            FetchBusy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     squash_count
`endif
);

    fetch_state_e    state;
    fetch_state_e    state_n;
    logic [XLEN-1:0] pcf;
    logic [XLEN-1:0] pcf_n;
    if_id_t          ifid_q;
    if_id_t          ifid_n;
    logic            valid_q;
    logic            valid_n;
    logic            ifid_we;

    logic            buf_load;
    logic            buf_unload;
    logic            buf_clear;
    logic            buf_full;
    if_id_t          buf_word;
    if_id_t          buf_held;

    assign buf_word = '{instr: imem_rdata, pc4: pc_next(pcf)};

    fetch_hold_buf u_hold_buf (
        .clk    (clk),
        .reset  (reset),
        .load   (buf_load),
        .unload (buf_unload),
        .clear  (buf_clear),
        .word   (buf_word),
        .held   (buf_held),
        .full   (buf_full)
    );

    always_comb begin
        state_n    = state;
        pcf_n      = pcf;
        ifid_we    = 1'b0;
        ifid_n     = '{instr: NOP_INSTR, pc4: ifid_q.pc4};
        valid_n    = 1'b0;
        buf_load   = 1'b0;
        buf_unload = 1'b0;
        buf_clear  = 1'b0;
        imem_req   = 1'b0;
        FetchBusy  = 1'b0;

        unique case (state)
            IDLE: begin
                FetchBusy = 1'b1;
                ifid_we   = !StallD;
                state_n   = REQ;
            end
            REQ: begin
                imem_req = !StallF;
                if (imem_ack) begin
                    if (!StallF) begin
                        pcf_n = pc_next(pcf);
                    end
                    if (StallD) begin
                        buf_load = 1'b1;
                        state_n  = HOLD;
                    end else begin
                        ifid_we = 1'b1;
                        ifid_n  = buf_word;
                        valid_n = 1'b1;
                    end
                end else begin
                    FetchBusy = 1'b1;
                    ifid_we   = !StallD;
                end
            end
            HOLD: begin
                if (!StallD) begin
                    state_n = REQ;
                    if (buf_full) begin
                        buf_unload = 1'b1;
                        ifid_we    = 1'b1;
                        ifid_n     = buf_held;
                        valid_n    = 1'b1;
                    end
                end
            end
            DROP: begin
                FetchBusy = 1'b1;
                ifid_we   = !StallD;
                if (imem_ack) begin
                    state_n = REQ;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A redirect overrides everything; an in-flight response must be drained.
        if (PCSrcD) begin
            pcf_n      = PCBranchD;
            ifid_we    = 1'b1;
            ifid_n     = '{instr: NOP_INSTR, pc4: ifid_q.pc4};
            valid_n    = 1'b0;
            buf_load   = 1'b0;
            buf_unload = 1'b0;
            buf_clear  = 1'b1;
            if ((state == REQ || state == DROP) && !imem_ack) begin
                state_n = DROP;
            end else begin
                state_n = REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pcf     <= RESET_PC;
            ifid_q  <= '{instr: NOP_INSTR, pc4: '0};
            valid_q <= 1'b0;
        end else begin
            state <= state_n;
            pcf   <= pcf_n;
            if (ifid_we) begin
                ifid_q  <= ifid_n;
                valid_q <= valid_n;
            end
        end
    end

    assign imem_addr = pcf;
    assign InstrD    = ifid_q.instr;
    assign PCPlus4D  = ifid_q.pc4;
    assign ValidD    = valid_q;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            squash_count <= '0;
        end else begin
            if (FetchBusy && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (PCSrcD && squash_count != '1) begin
                squash_count <= squash_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage.
// Covers FETCH_PERF_CNT_EN counters when the macro is defined.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        StallF;
    logic        StallD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        FetchBusy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] squash_count;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] pcf;
    logic [31:0] a;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .StallF     (StallF),
        .StallD     (StallD),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .FetchBusy  (FetchBusy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .squash_count (squash_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mem(input logic [31:0] addr);
        return {addr[23:0], 8'h33} ^ 32'h5A00_0000;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_st(input string tag, input fetch_state_e obs,
                          input fetch_state_e expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%s expected=%s", tag, obs.name(), expv.name());
        end
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p,
                        input logic v);
        sb.push_back('{instr: i, pc4: p, valid: v});
    endtask

    // One clock: drive inputs, check request side, then check IF/ID.
    task automatic step(input logic ack, input logic [31:0] rd,
                        input logic sd, input logic sf, input logic br,
                        input logic [31:0] tgt, input logic exp_req,
                        input logic exp_busy);
        exp_t e;
        imem_ack   = ack;
        imem_rdata = rd;
        StallD     = sd;
        StallF     = sf;
        PCSrcD     = br;
        PCBranchD  = tgt;
        #1;
        chk1("imem_req", imem_req, exp_req);
        chk1("FetchBusy", FetchBusy, exp_busy);
        chk32("imem_addr", imem_addr, pcf);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            chk32("InstrD", InstrD, e.instr);
            chk32("PCPlus4D", PCPlus4D, e.pc4);
            chk1("ValidD", ValidD, e.valid);
        end
        imem_ack = 1'b0;
        PCSrcD   = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        StallF     = 1'b0;
        StallD     = 1'b0;
        PCSrcD     = 1'b0;
        PCBranchD  = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        pcf        = 32'h0;

        @(posedge clk);
        #1;
        chk32("rst_InstrD", InstrD, 32'h13);
        chk32("rst_PCPlus4D", PCPlus4D, 32'h0);
        chk1("rst_ValidD", ValidD, 1'b0);
        chk1("rst_imem_req", imem_req, 1'b0);
        chk32("rst_imem_addr", imem_addr, 32'h0);
        chk_st("rst_state", dut.state, IDLE);
        reset = 1'b0;

        // IDLE for one cycle, then sequential fetch with ack every cycle
        push(32'h13, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            a = pcf;
            push(mem(a), a + 32'd4, 1'b1);
            step(1'b1, mem(a), 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            pcf = a + 32'd4;
        end

        // decode stall with ack during the stall
        push(mem(32'h8), 32'hC, 1'b1);
        step(1'b1, mem(32'hC), 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        pcf = 32'h10;
        chk_st("stall_state0", dut.state, HOLD);
        for (int i = 0; i < 2; i++) begin
            push(mem(32'h8), 32'hC, 1'b1);
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            chk_st("stall_state", dut.state, HOLD);
        end
        push(mem(32'hC), 32'h10, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk_st("unstall_state", dut.state, REQ);

        // redirect with response pending, late ack discarded
        push(32'h13, 32'h10, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
        pcf = 32'h100;
        chk_st("drop_state", dut.state, DROP);
        push(32'h13, 32'h10, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        push(32'h13, 32'h10, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk_st("drop_exit", dut.state, REQ);
        push(mem(32'h100), 32'h104, 1'b1);
        step(1'b1, mem(32'h100), 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        pcf = 32'h104;

        // flush beats a decode stall, coincident ack dropped
        push(32'h13, 32'h104, 1'b0);
        step(1'b1, mem(32'h104), 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
        pcf = 32'h200;
        chk_st("flush_state", dut.state, REQ);

        // missing ack makes a bubble
        push(32'h13, 32'h104, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        push(mem(32'h200), 32'h204, 1'b1);
        step(1'b1, mem(32'h200), 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        pcf = 32'h204;

        // PC wrap at the top of the address space
        push(32'h13, 32'h204, 1'b0);
        step(1'b1, mem(32'h204), 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        pcf = 32'hFFFF_FFFC;
        push(mem(32'hFFFF_FFFC), 32'h0, 1'b1);
        step(1'b1, mem(32'hFFFF_FFFC), 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        pcf = 32'h0;

        // StallF suppresses the request
        push(32'h13, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        push(mem(32'h0), 32'h4, 1'b1);
        step(1'b1, mem(32'h0), 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        pcf = 32'h4;

        // asynchronous reset mid-request with an ack arriving
        imem_ack   = 1'b1;
        imem_rdata = mem(32'h4);
        reset      = 1'b1;
        #1;
        chk32("mid_rst_InstrD", InstrD, 32'h13);
        chk1("mid_rst_ValidD", ValidD, 1'b0);
        chk32("mid_rst_addr", imem_addr, 32'h0);
        chk1("mid_rst_req", imem_req, 1'b0);
        @(posedge clk);
        #1;
        chk_st("mid_rst_state", dut.state, IDLE);
        chk32("mid_rst_PCPlus4D", PCPlus4D, 32'h0);
        chk1("mid_rst_ValidD2", ValidD, 1'b0);
        imem_ack = 1'b0;
        reset    = 1'b0;
        pcf      = 32'h0;

        // IDLE cycle, 5 unacked REQ cycles, two redirects
        push(32'h13, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            push(32'h13, 32'h0, 1'b0);
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        end
        push(32'h13, 32'h0, 1'b0);
        step(1'b1, mem(32'h0), 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
        pcf = 32'h40;
        push(32'h13, 32'h0, 1'b0);
        step(1'b1, mem(32'h40), 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0);
        pcf = 32'h80;
        chk32("redirect_addr", imem_addr, pcf);
`ifdef FETCH_PERF_CNT_EN
        // the IDLE cycle after reset is busy too, hence 1 + 5
        chk32("stall_cycles", stall_cycles, 32'd6);
        chk32("squash_count", squash_count, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
